// File: rtl/cpu_sequencer_if.sv
// Sequencer-facing bundle: run enable, imem/dmem handshakes, decoder class flags,
// register-file/PC strobes and status/counters. Sequencer side is the master.
interface cpu_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             run;
    logic             imem_req;
    logic             imem_ready;
    logic             ir_en;
    logic             dec_load;
    logic             dec_store;
    logic             dec_halt;
    logic             dec_illegal;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ready;
    logic             rf_we;
    logic             pc_en;
    logic             halted;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] instret;

    modport master (
        input  run, imem_ready, dec_load, dec_store, dec_halt, dec_illegal, dmem_ready,
        output imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en,
               halted, fault, fault_code, cycles, instret
    );

    modport slave (
        output run, imem_ready, dec_load, dec_store, dec_halt, dec_illegal, dmem_ready,
        input  imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en,
               halted, fault, fault_code, cycles, instret
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: fetch, decode-driven memory access, write-back
// and PC update, with bus timeouts, sticky halt/fault status and perf counters.
module cpu_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    cpu_sequencer_if.master   bus
);

    localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [1:0]        r_fault_code;
    logic [CNT_W-1:0]  r_cycles;
    logic [CNT_W-1:0]  r_instret;

    logic w_wait_expired;
    logic w_exec_fault;
    logic w_retire;
    logic w_halt_retire;
    logic w_active;

    // With TIMEOUT=0 the wait counter still runs but can never expire.
    assign w_wait_expired = (TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST);
    assign w_exec_fault   = bus.dec_illegal | (bus.dec_load & bus.dec_store);
    assign w_retire       = (r_state == S_WB) |
                            ((r_state == S_MEM) & bus.dmem_ready & bus.dec_store);
    assign w_halt_retire  = (r_state == S_EXEC) & ~w_exec_fault & bus.dec_halt;
    assign w_active       = (r_state == S_FETCH) | (r_state == S_EXEC) |
                            (r_state == S_MEM)   | (r_state == S_WB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_fault_code <= '0;
            r_cycles     <= '0;
            r_instret    <= '0;
        end else begin
            if (w_active)
                r_cycles <= r_cycles + CNT_W'(1);
            if (w_retire || w_halt_retire)
                r_instret <= r_instret + CNT_W'(1);

            unique case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_state    <= S_FETCH;
                        r_wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    // ready in the last allowed cycle takes precedence over the timeout
                    if (bus.imem_ready) begin
                        r_state <= S_EXEC;
                    end else if (w_wait_expired) begin
                        r_state      <= S_FAULT;
                        r_fault_code <= 2'b10;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_EXEC: begin
                    if (w_exec_fault) begin
                        r_state      <= S_FAULT;
                        r_fault_code <= 2'b01;
                    end else if (bus.dec_halt) begin
                        r_state <= S_HALT;
                    end else if (bus.dec_load || bus.dec_store) begin
                        r_state    <= S_MEM;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        if (bus.dec_store) begin
                            r_state    <= bus.run ? S_FETCH : S_IDLE;
                            r_wait_cnt <= '0;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (w_wait_expired) begin
                        r_state      <= S_FAULT;
                        r_fault_code <= 2'b11;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    r_state    <= bus.run ? S_FETCH : S_IDLE;
                    r_wait_cnt <= '0;
                end
                S_HALT:  r_state <= S_HALT;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_req   = (r_state == S_FETCH);
    assign bus.ir_en      = (r_state == S_FETCH) & bus.imem_ready;
    assign bus.dmem_req   = (r_state == S_MEM);
    assign bus.dmem_we    = (r_state == S_MEM) & bus.dec_store;
    assign bus.rf_we      = (r_state == S_WB);
    assign bus.pc_en      = w_retire;
    assign bus.halted     = (r_state == S_HALT);
    assign bus.fault      = (r_state == S_FAULT);
    assign bus.fault_code = r_fault_code;
    assign bus.cycles     = r_cycles;
    assign bus.instret    = r_instret;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the CPU datapath. It fetches an instruction word over a variable-latency instruction-memory handshake and loads the instruction register. It then uses the instruction-class flags from the instruction decoder to drive the data-memory handshake, register-file write and PC update. It also keeps cycle and retired-instruction counters, and latches halt and fault status.

Parameters:
TIMEOUT, 16, max cycles a memory request may wait for ready before a bus fault; 0 disables the timeout.
CNT_W, 32, width of the cycles and instret counters.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, synchronous, active-high.
run  in  1  enable; sampled only in IDLE and at instruction retire.
imem_req  out  1  instruction fetch request.
imem_ready  in  1  fetch data valid / request accepted.
ir_en  out  1  load instruction register (one-cycle pulse).
dec_load  in  1  decoder: load instruction; valid EXEC through WB.
dec_store  in  1  decoder: store instruction.
dec_halt  in  1  decoder: halt instruction.
dec_illegal  in  1  decoder: unrecognised opcode.
dmem_req  out  1  data memory request.
dmem_we  out  1  data memory write enable.
dmem_ready  in  1  data memory access complete.
rf_we  out  1  register-file write enable.
pc_en  out  1  PC update strobe (one-cycle pulse).
halted  out  1  sticky halt status.
fault  out  1  sticky fault status.
fault_code  out  2  fault cause: 01 illegal, 10 imem timeout, 11 dmem timeout; 00 when no fault.
cycles  out  CNT_W  active cycle counter.
instret  out  CNT_W  retired instruction counter.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; cycles=0, instret=0, wait_cnt=0, fault_code=00.
  - All outputs are 0 from the cycle after the reset edge.
  - rst overrides any state, including mid-handshake; requests drop immediately after the edge.
- Output decoding: all control outputs are decoded combinationally from the registered state and current inputs. No output is driven outside the states listed below.
- States and transitions:
  - IDLE: no outputs asserted. run=1 -> FETCH.
  - FETCH: imem_req=1.
    - imem_ready=1 -> ir_en=1 in the same cycle; next state EXEC.
  - EXEC: one cycle, decision only. Priority order:
    1. dec_illegal, or (dec_load & dec_store) -> FAULT, code 01.
    2. dec_halt -> HALT; instret++.
    3. dec_load or dec_store -> MEM.
    4. otherwise -> WB.
  - MEM: dmem_req=1, dmem_we=dec_store.
    - dmem_ready=1 and load -> WB.
    - dmem_ready=1 and store -> retire in this cycle.
  - WB: rf_we=1; retire in this cycle.
  - HALT: halted=1. Exited only by rst; run is ignored.
  - FAULT: fault=1, fault_code held. Exited only by rst.
- Retire:
  - pc_en=1 and instret++ in the retire cycle.
  - Next state is FETCH if run=1, else IDLE.
  - Deasserting run mid-instruction never aborts that instruction.
- Timeout:
  - wait_cnt clears on entry to FETCH or MEM and increments each cycle ready is low there.
  - If ready is low while wait_cnt==TIMEOUT-1 -> FAULT next cycle (code 10 from FETCH, 11 from MEM). The request is therefore high for at most TIMEOUT cycles.
  - Ready in the final allowed cycle wins over timeout.
- Counters:
  - cycles increments every cycle state is FETCH, EXEC, MEM or WB.
  - Both counters wrap modulo 2^CNT_W.
- Latency with zero-wait memories: ALU op 3 cycles (FETCH, EXEC, WB); load 4; store 3.
- Decoder inputs are assumed stable while the IR is held (EXEC through WB); the sequencer does not register them.

Test Plan:
1. ALU stream: rst, run=1, imem_ready tied 1, no dec_* flags, 10 instructions -> ir_en every 3rd cycle; rf_we and pc_en pulse in WB; instret=10, cycles=30.
2. Load, dmem_ready after 3 low cycles -> dmem_req high 4 cycles with dmem_we=0; then WB with rf_we=1; 7 cycles total; instret+1.
3. Store, dmem_ready immediate -> dmem_we=1 for 1 cycle, pc_en in the same cycle, rf_we never asserted; 3 cycles.
4. imem_ready held 0, TIMEOUT=16 -> imem_req high exactly 16 cycles, then fault=1 and fault_code=10 with imem_req=0. Ready on the 16th cycle instead -> normal fetch. rst -> all outputs 0.
5. dec_halt -> halted=1, instret+1, run toggling ignored. Separately, dec_illegal and dec_halt together -> fault_code=01, halted=0.
6. run dropped during MEM wait -> store completes (pc_en pulse), state IDLE, no imem_req. run=1 again -> fetch resumes the next cycle.
